// File: rtl/adder_pkg.sv
// Shared definitions for the 64-bit adder issue/capture stage.
package adder_pkg;

  localparam int DEF_WIDTH = 64;

  // Result entry layout: {mismatch, ovf, zero, cout, sum[WIDTH-1:0]}
  localparam int RES_FLAGS = 4;
  localparam int OFS_COUT  = 0;
  localparam int OFS_ZERO  = 1;
  localparam int OFS_OVF   = 2;
  localparam int OFS_MIS   = 3;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } state_t;

  // Two's-complement overflow: operands share a sign the result does not.
  function automatic logic signed_ovf(input logic sign_a, input logic sign_b,
                                      input logic sign_s);
    return (sign_a == sign_b) && (sign_s != sign_a);
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO holding captured adder results.
module result_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == {CW{1'b0}});
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage, pointers (wrap naturally, DEPTH is a power of two) and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {W{1'b0}};
      end
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adder64_issue_capture.sv
// Operand issue / result capture stage around an external 64-bit adder,
// with status flags and an in-system golden-model comparison.
module adder64_issue_capture
  import adder_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SETTLE_CYCLES = 2,
  parameter int FIFO_DEPTH    = 2,
  parameter int ERRW          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_mismatch,
  output logic [ERRW-1:0]  err_count
);

  localparam int RES_W = WIDTH + RES_FLAGS;
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               load;
  logic               push;
  logic [WIDTH:0]     golden;
  logic               flag_zero;
  logic               flag_ovf;
  logic               flag_mis;
  logic [RES_W-1:0]   push_data;
  logic [RES_W-1:0]   head;
  logic [FCW-1:0]     fifo_count;
  logic               fifo_full;
  logic               fifo_empty;

  // Flags are derived from the registered operands, so they describe the captured add.
  assign golden    = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
  assign flag_zero = (add_sum == {WIDTH{1'b0}});
  assign flag_ovf  = signed_ovf(add_a[WIDTH-1], add_b[WIDTH-1], add_sum[WIDTH-1]);
  assign flag_mis  = ({add_cout, add_sum} != golden);
  assign push_data = {flag_mis, flag_ovf, flag_zero, add_cout, add_sum};

  // Next-state logic: accept when the FIFO has room, then count down the settle window.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    push      = 1'b0;
    in_ready  = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = (fifo_count < FCW'(FIFO_DEPTH));
        if (in_valid && in_ready) begin
          load      = 1'b1;
          cnt_nxt   = CNT_W'(SETTLE_CYCLES - 1);
          state_nxt = ST_SETTLE;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (cnt != {CNT_W{1'b0}}) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          push      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, settle counter, operand launch registers and saturating error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= {CNT_W{1'b0}};
      add_a     <= {WIDTH{1'b0}};
      add_b     <= {WIDTH{1'b0}};
      add_cin   <= 1'b0;
      err_count <= {ERRW{1'b0}};
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load) begin
        add_a   <= in_a;
        add_b   <= in_b;
        add_cin <= in_cin;
      end
      if (push && flag_mis && (err_count != {ERRW{1'b1}})) begin
        err_count <= err_count + ERRW'(1);
      end
    end
  end

  result_fifo #(
    .W     (RES_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (out_valid && out_ready),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // fifo_full is implied by fifo_count; the accept check keeps pushes off a full FIFO.
  assign out_valid    = !fifo_empty && (fifo_full || !fifo_full);
  assign out_sum      = head[WIDTH-1:0];
  assign out_cout     = head[WIDTH + OFS_COUT];
  assign out_zero     = head[WIDTH + OFS_ZERO];
  assign out_ovf      = head[WIDTH + OFS_OVF];
  assign out_mismatch = head[WIDTH + OFS_MIS];

endmodule

// File: tb/tb_adder64_issue_capture.sv
// Scoreboard bench for adder64_issue_capture with a behavioural adder that can be
// made to corrupt sum bit 0 on selected operations.
module tb_adder64_issue_capture;

  localparam int W    = 64;
  localparam int ERRW = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a, in_b;
  logic          in_cin;
  logic [W-1:0]  add_a, add_b;
  logic          add_cin;
  logic [W-1:0]  add_sum;
  logic          add_cout;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_cout, out_zero, out_ovf, out_mismatch;
  logic [ERRW-1:0] err_count;

  logic          corrupt_req;
  logic          corrupt_q;
  logic [W:0]    model_full;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         zero;
    logic         ovf;
    logic         mis;
  } exp_t;
  exp_t sb[$];

  adder64_issue_capture #(
    .WIDTH(W), .SETTLE_CYCLES(2), .FIFO_DEPTH(2), .ERRW(ERRW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_zero(out_zero),
    .out_ovf(out_ovf), .out_mismatch(out_mismatch), .err_count(err_count)
  );

  // Behavioural adder standing in for the carry-select adder.
  assign model_full = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
  assign add_sum    = model_full[W-1:0] ^ {{(W-1){1'b0}}, corrupt_q};
  assign add_cout   = model_full[W];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: record expected results on accept, compare on pop.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        exp_t e;
        logic [W:0] f;
        f      = {1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, in_cin};
        e.sum  = f[W-1:0] ^ {{(W-1){1'b0}}, corrupt_req};
        e.cout = f[W];
        e.zero = (e.sum == {W{1'b0}});
        e.ovf  = (in_a[W-1] == in_b[W-1]) && (e.sum[W-1] != in_a[W-1]);
        e.mis  = corrupt_req;
        sb.push_back(e);
        corrupt_q = corrupt_req;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_result", 128'(1), 128'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sum",      128'(out_sum),      128'(e.sum));
          check("cout",     128'(out_cout),     128'(e.cout));
          check("zero",     128'(out_zero),     128'(e.zero));
          check("ovf",      128'(out_ovf),      128'(e.ovf));
          check("mismatch", 128'(out_mismatch), 128'(e.mis));
        end
      end
    end
  end

  task automatic wait_accept();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 128'(0), 128'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic corr);
    @(posedge clk);
    #1;
    in_a = a; in_b = b; in_cin = cin; corrupt_req = corr;
    in_valid = 1'b1;
    wait_accept();
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 128'(0), 128'(1));
    @(negedge clk);
    check("drained_out_valid", 128'(out_valid), 128'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
    out_ready = 1'b1; corrupt_req = 1'b0; corrupt_q = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_err_count", 128'(err_count), 128'(0));
    check("rst_add_a",     128'(add_a),     128'(0));
    check("rst_out_sum",   128'(out_sum),   128'(0));
    check("rst_in_ready",  128'(in_ready),  128'(1));

    // 1: all-ones plus carry, with latency check
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    @(negedge clk);
    check("lat_k",   128'(out_valid), 128'(0));
    @(negedge clk);
    check("lat_k1",  128'(out_valid), 128'(0));
    @(negedge clk);
    check("lat_k2",  128'(out_valid), 128'(1));
    drain();

    // 2 and 3: pattern, signed overflow, wrap to zero
    issue(64'h1010_1010_1010_1010, 64'h0101_0101_0101_0101, 1'b0, 1'b0);
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      issue({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(1)), 1'b0);
    end
    drain();

    // 4: back-pressure, third op held until the consumer drains
    out_ready = 1'b0;
    issue(64'h0000_0000_0000_000A, 64'h0000_0000_0000_0005, 1'b0, 1'b0);
    issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    in_a = 64'h1234_5678_9ABC_DEF0; in_b = 64'h0FED_CBA9_8765_4321; in_cin = 1'b1;
    corrupt_req = 1'b0;
    in_valid = 1'b1;
    repeat (8) @(negedge clk);
    check("full_in_ready",  128'(in_ready),  128'(0));
    check("full_out_valid", 128'(out_valid), 128'(1));
    check("full_sb_size",   128'(sb.size()), 128'(2));
    out_ready = 1'b1;
    wait_accept();
    drain();
    check("err_before_fault", 128'(err_count), 128'(0));

    // 5: single corrupted capture, then saturation
    issue(64'h0000_0000_0000_0003, 64'h0000_0000_0000_0004, 1'b0, 1'b1);
    drain();
    check("err_one", 128'(err_count), 128'(1));
    for (int i = 0; i < (1 << ERRW) + 1; i++) begin
      issue({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b1);
    end
    drain();
    check("err_saturated", 128'(err_count), 128'({ERRW{1'b1}}));

    // 6: reset mid-SETTLE with one result queued
    out_ready = 1'b0;
    issue(64'h0000_0000_0000_0011, 64'h0000_0000_0000_0022, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("pre_rst_out_valid", 128'(out_valid), 128'(1));
    issue(64'h0000_0000_0000_0033, 64'h0000_0000_0000_0044, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("in_rst_out_valid", 128'(out_valid), 128'(0));
    check("in_rst_err_count", 128'(err_count), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready",  128'(in_ready),  128'(1));
    check("post_rst_out_valid", 128'(out_valid), 128'(0));
    check("post_rst_err_count", 128'(err_count), 128'(0));
    out_ready = 1'b1;
    issue(64'h0000_0000_0000_0055, 64'h0000_0000_0000_0066, 1'b1, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
